// File: rtl/uno_pkg.sv
// Shared card/seat types, card value constants and scheduler state encoding for the UNO turn scheduler.
package uno_pkg;

    localparam int unsigned CARD_W  = 6;
    localparam int unsigned SEAT_W  = 2;
    localparam int unsigned VALUE_W = 4;
    localparam int unsigned COLOR_W = 2;
    localparam int unsigned PEND_W  = 3;

    typedef logic [CARD_W-1:0]  card_t;
    typedef logic [SEAT_W-1:0]  seat_t;
    typedef logic [VALUE_W-1:0] value_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam value_t CARD_SKIP  = 4'd10;
    localparam value_t CARD_REV   = 4'd11;
    localparam value_t CARD_D2    = 4'd12;
    localparam value_t CARD_WILD  = 4'd13;
    localparam value_t CARD_WD4   = 4'd14;
    localparam card_t  CARD_EMPTY = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_CHECK,
        ST_DRAW,
        ST_END
    } sched_state_e;

    function automatic logic card_is_wild(input card_t c);
        return (c[3:0] == CARD_WILD) || (c[3:0] == CARD_WD4);
    endfunction

endpackage

// File: rtl/uno_card_rules.sv
// Combinational card rules: legality of an offered card, resulting direction, next seat, victim and penalty.
module uno_card_rules
    import uno_pkg::*;
(
    input  card_t              card_i,
    input  card_t              last_card_i,
    input  color_t             cur_color_i,
    input  seat_t              turn_i,
    input  logic               dir_i,
    output logic               legal_o,
    output logic               wild_o,
    output logic               dir_o,
    output seat_t              step_o,
    output seat_t              next_o,
    output seat_t              victim_o,
    output logic [PEND_W-1:0]  penalty_o
);

    value_t value;
    seat_t  rev_step;

    always_comb begin
        value     = card_i[3:0];
        wild_o    = card_is_wild(card_i);
        legal_o   = (value == last_card_i[3:0]) || (card_i[5:4] == cur_color_i) || wild_o;
        dir_o     = dir_i;
        step_o    = dir_i ? 2'd3 : 2'd1;
        rev_step  = dir_i ? 2'd1 : 2'd3;
        victim_o  = seat_t'(turn_i + step_o);
        next_o    = seat_t'(turn_i + step_o);
        penalty_o = '0;
        // Penalty cards skip the victim: next seat is two steps on, like a skip
        case (value)
            CARD_SKIP: next_o = seat_t'(turn_i + {step_o[0], 1'b0});
            CARD_REV: begin
                dir_o  = ~dir_i;
                next_o = seat_t'(turn_i + rev_step);
            end
            CARD_D2: begin
                penalty_o = 3'd2;
                next_o    = seat_t'(turn_i + {step_o[0], 1'b0});
            end
            CARD_WD4: begin
                penalty_o = 3'd4;
                next_o    = seat_t'(turn_i + {step_o[0], 1'b0});
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uno_turn_scheduler.sv
// UNO 4-seat turn scheduler: turn order, direction, discard top, active colour and draw penalties.
// Optional idle-turn timeout (forced pass) is enabled by defining UNO_TURN_TIMEOUT_EN.
module uno_turn_scheduler
    import uno_pkg::*;
#(
    parameter int unsigned NUM_SEATS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_play_valid,
    input  logic [5:0]        i_play_card,
    input  logic [1:0]        i_play_color,
    input  logic              i_pass,
    output logic              o_play_ready,
    output logic              o_reject,
    input  logic [3:0]        i_hand_zero,
    output logic              o_draw_req,
    output logic [1:0]        o_draw_seat,
    input  logic              i_draw_ack,
    input  logic              i_deck_empty,
    output logic [1:0]        o_turn,
    output logic              o_dir,
    output logic [5:0]        o_last_card,
    output logic [1:0]        o_cur_color,
    output logic              o_select_color,
    output logic [2:0]        o_pending,
    output logic              o_end,
    output logic [1:0]        o_winner
);

    // Start is refused for a configuration the 2-bit seat arithmetic cannot serve
    localparam bit CFG_OK = (NUM_SEATS == 4) && (TIMEOUT_CYCLES > 1);

    sched_state_e       state_q;
    seat_t              turn_q, next_q, victim_q, winner_q;
    card_t              last_q;
    color_t             color_q;
    logic               dir_q, played_q, reject_q, draw_req_q, end_q;
    logic [PEND_W-1:0]  pending_q;

    logic               legal_c, wild_c, dir_c;
    seat_t              step_c, next_c, victim_c;
    logic [PEND_W-1:0]  penalty_c;
    logic               force_pass_c, accept_c, pass_c;

    uno_card_rules u_rules (
        .card_i      (i_play_card),
        .last_card_i (last_q),
        .cur_color_i (color_q),
        .turn_i      (turn_q),
        .dir_i       (dir_q),
        .legal_o     (legal_c),
        .wild_o      (wild_c),
        .dir_o       (dir_c),
        .step_o      (step_c),
        .next_o      (next_c),
        .victim_o    (victim_c),
        .penalty_o   (penalty_c)
    );

    assign pass_c   = (state_q == ST_TURN) && !(i_play_valid && legal_c) &&
                      ((i_pass && !i_play_valid) || force_pass_c);
    assign accept_c = ((state_q == ST_TURN) && i_play_valid && legal_c) || pass_c;

`ifdef UNO_TURN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q;

    // Idle cycles spent by the seat holding the turn
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || state_q != ST_TURN || accept_c) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= TO_W'(to_cnt_q + 1'b1);
        end
    end

    assign force_pass_c = (state_q == ST_TURN) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign force_pass_c = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            turn_q     <= '0;
            next_q     <= '0;
            victim_q   <= '0;
            winner_q   <= '0;
            last_q     <= CARD_EMPTY;
            color_q    <= '0;
            dir_q      <= 1'b0;
            played_q   <= 1'b0;
            reject_q   <= 1'b0;
            draw_req_q <= 1'b0;
            end_q      <= 1'b0;
            pending_q  <= '0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start && CFG_OK) begin
                        last_q  <= i_play_card;
                        color_q <= card_is_wild(i_play_card) ? 2'd0 : i_play_card[5:4];
                        turn_q  <= '0;
                        state_q <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (i_play_valid && legal_c) begin
                        last_q    <= i_play_card;
                        color_q   <= wild_c ? i_play_color : i_play_card[5:4];
                        dir_q     <= dir_c;
                        next_q    <= next_c;
                        victim_q  <= victim_c;
                        pending_q <= penalty_c;
                        played_q  <= 1'b1;
                        state_q   <= ST_CHECK;
                    end else if (pass_c) begin
                        pending_q <= 3'd1;
                        victim_q  <= turn_q;
                        next_q    <= seat_t'(turn_q + step_c);
                        played_q  <= 1'b0;
                        state_q   <= ST_CHECK;
                    end else if (i_play_valid) begin
                        reject_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Win is judged on the seat that just played, before any draws
                    if (played_q && i_hand_zero[turn_q]) begin
                        end_q     <= 1'b1;
                        winner_q  <= turn_q;
                        pending_q <= '0;
                        state_q   <= ST_END;
                    end else if (pending_q != '0 && !i_deck_empty) begin
                        draw_req_q <= 1'b1;
                        state_q    <= ST_DRAW;
                    end else begin
                        pending_q <= '0;
                        turn_q    <= next_q;
                        state_q   <= ST_TURN;
                    end
                end
                ST_DRAW: begin
                    if (i_deck_empty) begin
                        pending_q  <= '0;
                        draw_req_q <= 1'b0;
                        turn_q     <= next_q;
                        state_q    <= ST_TURN;
                    end else if (i_draw_ack) begin
                        pending_q <= PEND_W'(pending_q - 1'b1);
                        if (pending_q == 3'd1) begin
                            draw_req_q <= 1'b0;
                            turn_q     <= next_q;
                            state_q    <= ST_TURN;
                        end
                    end
                end
                ST_END: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_play_ready   = (state_q == ST_TURN);
    assign o_reject       = reject_q;
    assign o_draw_req     = draw_req_q;
    assign o_draw_seat    = victim_q;
    assign o_turn         = turn_q;
    assign o_dir          = dir_q;
    assign o_last_card    = last_q;
    assign o_cur_color    = color_q;
    assign o_select_color = card_is_wild(last_q);
    assign o_pending      = pending_q;
    assign o_end          = end_q;
    assign o_winner       = winner_q;

endmodule

// File: tb/tb_uno_turn_scheduler.sv
// Directed self-checking bench for uno_turn_scheduler (default build, timeout feature disabled).
module tb_uno_turn_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_start, i_play_valid, i_pass, i_draw_ack, i_deck_empty;
    logic [5:0] i_play_card;
    logic [1:0] i_play_color;
    logic [3:0] i_hand_zero;
    logic       o_play_ready, o_reject, o_draw_req, o_dir, o_select_color, o_end;
    logic [1:0] o_draw_seat, o_turn, o_cur_color, o_winner;
    logic [5:0] o_last_card;
    logic [2:0] o_pending;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    uno_turn_scheduler dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_play_valid(i_play_valid), .i_play_card(i_play_card), .i_play_color(i_play_color),
        .i_pass(i_pass), .o_play_ready(o_play_ready), .o_reject(o_reject),
        .i_hand_zero(i_hand_zero), .o_draw_req(o_draw_req), .o_draw_seat(o_draw_seat),
        .i_draw_ack(i_draw_ack), .i_deck_empty(i_deck_empty), .o_turn(o_turn), .o_dir(o_dir),
        .o_last_card(o_last_card), .o_cur_color(o_cur_color), .o_select_color(o_select_color),
        .o_pending(o_pending), .o_end(o_end), .o_winner(o_winner)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic start_game(input logic [5:0] card);
        i_play_card = card;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    // Offer a card for one cycle, then let the CHECK cycle complete
    task automatic play(input logic [5:0] card, input logic [1:0] color);
        i_play_valid = 1'b1;
        i_play_card  = card;
        i_play_color = color;
        tick();
        i_play_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_last_card !== 6'h3F) begin errors++; $display("FAIL reset_last: got %h want 3f", o_last_card); end
        checks++; if ({o_turn, o_dir, o_cur_color, o_pending, o_end, o_draw_req, o_play_ready, o_reject, o_select_color} !== 13'd0) begin
            errors++; $display("FAIL reset_outputs: got turn=%0d dir=%0d col=%0d pend=%0d end=%0d req=%0d rdy=%0d rej=%0d sel=%0d want all 0",
                               o_turn, o_dir, o_cur_color, o_pending, o_end, o_draw_req, o_play_ready, o_reject, o_select_color);
        end
        // Reach DRAW via a draw-two, then reset in the middle of it
        start_game(6'h15);
        i_play_valid = 1'b1; i_play_card = 6'h1C; tick(); i_play_valid = 1'b0;
        tick();
        checks++; if (o_draw_req !== 1'b1 || o_pending !== 3'd2 || o_draw_seat !== 2'd1) begin
            errors++; $display("FAIL d2_draw_entry: got req=%0d pend=%0d seat=%0d want 1 2 1", o_draw_req, o_pending, o_draw_seat);
        end
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        checks++; if (o_draw_req !== 1'b0 || o_last_card !== 6'h3F || o_turn !== 2'd0 || o_play_ready !== 1'b0 || o_pending !== 3'd0) begin
            errors++; $display("FAIL reset_mid_draw: got req=%0d last=%h turn=%0d rdy=%0d pend=%0d want 0 3f 0 0 0",
                               o_draw_req, o_last_card, o_turn, o_play_ready, o_pending);
        end
        // IDLE ignores plays without a start
        i_play_valid = 1'b1; i_play_card = 6'h25; tick(); i_play_valid = 1'b0;
        checks++; if (o_last_card !== 6'h3F || o_play_ready !== 1'b0) begin
            errors++; $display("FAIL idle_ignores_play: got last=%h rdy=%0d want 3f 0", o_last_card, o_play_ready);
        end
    endtask

    task automatic test_play_reject();
        start_game(6'h15);
        checks++; if (o_last_card !== 6'h15 || o_cur_color !== 2'd1 || o_turn !== 2'd0 || o_play_ready !== 1'b1) begin
            errors++; $display("FAIL start: got last=%h col=%0d turn=%0d rdy=%0d want 15 1 0 1", o_last_card, o_cur_color, o_turn, o_play_ready);
        end
        play(6'h25, 2'd0);
        checks++; if (o_turn !== 2'd1 || o_last_card !== 6'h25 || o_cur_color !== 2'd2) begin
            errors++; $display("FAIL value_match_play: got turn=%0d last=%h col=%0d want 1 25 2", o_turn, o_last_card, o_cur_color);
        end
        i_play_valid = 1'b1; i_play_card = 6'h37; tick(); i_play_valid = 1'b0;
        checks++; if (o_reject !== 1'b1) begin errors++; $display("FAIL reject_pulse: got %0d want 1", o_reject); end
        tick();
        checks++; if (o_reject !== 1'b0 || o_turn !== 2'd1 || o_last_card !== 6'h25) begin
            errors++; $display("FAIL reject_after: got rej=%0d turn=%0d last=%h want 0 1 25", o_reject, o_turn, o_last_card);
        end
    endtask

    task automatic test_skip_reverse();
        play(6'h26, 2'd0);
        play(6'h27, 2'd0);
        checks++; if (o_turn !== 2'd3) begin errors++; $display("FAIL to_seat3: got %0d want 3", o_turn); end
        play(6'h2A, 2'd0);
        checks++; if (o_turn !== 2'd1 || o_dir !== 1'b0) begin errors++; $display("FAIL skip_wrap: got turn=%0d dir=%0d want 1 0", o_turn, o_dir); end
        play(6'h2B, 2'd0);
        checks++; if (o_turn !== 2'd0 || o_dir !== 1'b1) begin errors++; $display("FAIL reverse: got turn=%0d dir=%0d want 0 1", o_turn, o_dir); end
        play(6'h21, 2'd0);
        checks++; if (o_turn !== 2'd3) begin errors++; $display("FAIL ccw_wrap: got %0d want 3", o_turn); end
    endtask

    task automatic test_wd4_win();
        int acks;
        do_reset();
        start_game(6'h15);
        i_play_valid = 1'b1; i_play_card = 6'h0E; i_play_color = 2'd2; tick(); i_play_valid = 1'b0;
        checks++; if (o_cur_color !== 2'd2 || o_select_color !== 1'b1 || o_pending !== 3'd4 || o_last_card !== 6'h0E) begin
            errors++; $display("FAIL wd4_accept: got col=%0d sel=%0d pend=%0d last=%h want 2 1 4 0e", o_cur_color, o_select_color, o_pending, o_last_card);
        end
        tick();
        checks++; if (o_draw_req !== 1'b1 || o_draw_seat !== 2'd1) begin
            errors++; $display("FAIL wd4_req: got req=%0d seat=%0d want 1 1", o_draw_req, o_draw_seat);
        end
        acks = 0;
        while (o_draw_req === 1'b1 && acks < 20) begin
            i_draw_ack = 1'b1;
            tick();
            acks++;
        end
        i_draw_ack = 1'b0;
        checks++; if (acks !== 4 || o_turn !== 2'd2 || o_pending !== 3'd0 || o_draw_req !== 1'b0) begin
            errors++; $display("FAIL wd4_draws: got acks=%0d turn=%0d pend=%0d req=%0d want 4 2 0 0", acks, o_turn, o_pending, o_draw_req);
        end
        i_hand_zero = 4'b0100;
        play(6'h23, 2'd0);
        checks++; if (o_end !== 1'b1 || o_winner !== 2'd2 || o_play_ready !== 1'b0) begin
            errors++; $display("FAIL win: got end=%0d winner=%0d rdy=%0d want 1 2 0", o_end, o_winner, o_play_ready);
        end
        i_start = 1'b1; i_play_valid = 1'b1; i_pass = 1'b1; i_play_card = 6'h25;
        tick(); tick(); tick();
        i_start = 1'b0; i_play_valid = 1'b0; i_pass = 1'b0; i_hand_zero = 4'b0000;
        checks++; if (o_end !== 1'b1 || o_winner !== 2'd2 || o_last_card !== 6'h23 || o_turn !== 2'd2 || o_draw_req !== 1'b0) begin
            errors++; $display("FAIL end_hold: got end=%0d winner=%0d last=%h turn=%0d req=%0d want 1 2 23 2 0",
                               o_end, o_winner, o_last_card, o_turn, o_draw_req);
        end
    endtask

    task automatic test_start_wild();
        do_reset();
        start_game(6'h3D);
        checks++; if (o_cur_color !== 2'd0 || o_select_color !== 1'b1 || o_last_card !== 6'h3D) begin
            errors++; $display("FAIL start_wild: got col=%0d sel=%0d last=%h want 0 1 3d", o_cur_color, o_select_color, o_last_card);
        end
        play(6'h07, 2'd3);
        checks++; if (o_turn !== 2'd1 || o_cur_color !== 2'd0 || o_select_color !== 1'b0) begin
            errors++; $display("FAIL after_wild_start: got turn=%0d col=%0d sel=%0d want 1 0 0", o_turn, o_cur_color, o_select_color);
        end
    endtask

    task automatic test_pass();
        logic saw_req;
        do_reset();
        start_game(6'h15);
        i_deck_empty = 1'b1;
        i_pass = 1'b1; tick(); i_pass = 1'b0;
        saw_req = o_draw_req;
        tick();
        saw_req = saw_req | o_draw_req;
        checks++; if (saw_req !== 1'b0 || o_turn !== 2'd1 || o_pending !== 3'd0) begin
            errors++; $display("FAIL pass_deck_empty: got req_seen=%0d turn=%0d pend=%0d want 0 1 0", saw_req, o_turn, o_pending);
        end
        i_deck_empty = 1'b0;
        i_pass = 1'b1; tick(); i_pass = 1'b0;
        tick();
        checks++; if (o_draw_req !== 1'b1 || o_draw_seat !== 2'd1 || o_pending !== 3'd1) begin
            errors++; $display("FAIL pass_req: got req=%0d seat=%0d pend=%0d want 1 1 1", o_draw_req, o_draw_seat, o_pending);
        end
        i_draw_ack = 1'b1; tick(); i_draw_ack = 1'b0;
        checks++; if (o_draw_req !== 1'b0 || o_turn !== 2'd2) begin
            errors++; $display("FAIL pass_done: got req=%0d turn=%0d want 0 2", o_draw_req, o_turn);
        end
        // Play and pass together: the play wins, no draw follows
        i_pass = 1'b1;
        i_play_valid = 1'b1; i_play_card = 6'h19; tick(); i_play_valid = 1'b0; i_pass = 1'b0;
        checks++; if (o_last_card !== 6'h19 || o_pending !== 3'd0) begin
            errors++; $display("FAIL play_beats_pass: got last=%h pend=%0d want 19 0", o_last_card, o_pending);
        end
        tick();
        checks++; if (o_turn !== 2'd3 || o_draw_req !== 1'b0) begin
            errors++; $display("FAIL play_beats_pass_turn: got turn=%0d req=%0d want 3 0", o_turn, o_draw_req);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_play_valid = 1'b0; i_pass = 1'b0;
        i_draw_ack = 1'b0; i_deck_empty = 1'b0; i_play_card = 6'h00;
        i_play_color = 2'd0; i_hand_zero = 4'b0000;
        test_reset();
        test_play_reject();
        test_skip_reverse();
        test_wd4_win();
        test_start_wild();
        test_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
